// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle add/sub/slt/and/or plus a signed
// restoring divider producing quotient (lo) and remainder (hi).
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             qneg;
  logic             rneg;

  logic             accept;
  logic             is_div;
  logic             b_zero;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign accept = start && (state == IDLE);
  assign is_div = (alucontrol == OP_DIV);
  assign b_zero = (b == '0);

  assign a_mag = a[WIDTH-1] ? ('0 - a) : a;
  assign b_mag = b[WIDTH-1] ? ('0 - b) : b;

  // One restoring step: shift next dividend bit in, trial-subtract.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign ge     = ~diff[WIDTH];

  assign q_fin = qneg ? ('0 - quo) : quo;
  assign r_fin = rneg ? ('0 - rem) : rem;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      alucontrol == OP_ADD: alu_res = a + b;
      alucontrol == OP_SUB: alu_res = a - b;
      alucontrol == OP_SLT:
        alu_res = {{(WIDTH-1){1'b0}},
                   ($signed(a) < $signed(b))};
      alucontrol == OP_AND: alu_res = a & b;
      alucontrol == OP_OR:  alu_res = a | b;
      default:              alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && is_div && !b_zero) state_n = DIV;
      DIV:  if (cnt == CW'(WIDTH - 1))       state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      dvs         <= '0;
      quo         <= '0;
      rem         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (is_div && !b_zero) begin
          busy        <= 1'b1;
          cnt         <= '0;
          dvs         <= b_mag;
          quo         <= a_mag;
          rem         <= '0;
          qneg        <= a[WIDTH-1] ^ b[WIDTH-1];
          rneg        <= a[WIDTH-1];
          div_by_zero <= 1'b0;
        end else begin
          result      <= alu_res;
          zero        <= (alu_res == '0);
          done        <= 1'b1;
          div_by_zero <= is_div;
        end
      end else if (state == DIV) begin
        cnt <= cnt + 1'b1;
        rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ge};
      end else if (state == FIX) begin
        lo     <= q_fin;
        hi     <= r_fin;
        result <= q_fin;
        zero   <= (q_fin == '0);
        busy   <= 1'b0;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed vector table, hand sequences,
// and random ops checked against a plain-arithmetic model.
module tb_multicycle_alu;

  localparam int W = 32;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] DIV = 4'b1010;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   alucontrol;
  logic [W-1:0] a, b;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done, div_by_zero;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] m_hi, m_lo;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alucontrol(alucontrol), .a(a), .b(b),
    .result(result), .zero(zero), .busy(busy),
    .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] x, y;
    bit           poke;
    logic [W-1:0] res;
    logic         z, dbz;
    logic [W-1:0] eh, el;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      n_chk++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_done_overlap: got 1 expected 0");
      end
    end
  end

  // Reference model: signed divide via 64-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, y,
                       output logic [W-1:0] res, output logic z,
                       output logic dbz, output int lat);
    longint sx, sy, q, r;
    res = '0; dbz = 1'b0; lat = 0;
    case (op)
      ADD: res = x + y;
      SUB: res = x - y;
      SLT: res = ($signed(x) < $signed(y)) ? 1 : 0;
      AND: res = x & y;
      OR:  res = x | y;
      DIV: begin
        if (y == 0) dbz = 1'b1;
        else begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          q = sx / sy;
          r = sx % sy;
          m_lo = q[W-1:0];
          m_hi = r[W-1:0];
          res = m_lo;
          lat = W + 1;
        end
      end
      default: res = '0;
    endcase
    z = (res == 0);
  endtask

  task automatic run_op(input string nm, input logic [3:0] op,
                        input logic [W-1:0] x, y, input bit poke,
                        input logic [W-1:0] er, input logic ez,
                        input logic ed, input logic [W-1:0] eh, el,
                        input int elat);
    int k;
    @(negedge clk);
    start = 1'b1; alucontrol = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; alucontrol = ADD;
    k = 0;
    while (!done && k < 60) begin
      if (poke) begin
        start = (k == 5);
        a = 1; b = 1;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk({nm, "_lat"}, k, elat);
    chk({nm, "_res"}, result, er);
    chk({nm, "_zero"}, zero, ez);
    chk({nm, "_dbz"}, div_by_zero, ed);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_busy"}, busy, 0);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] er, x, y;
    logic ez, ed;
    int lat, k;
    logic [3:0] op;
    logic [3:0] ops[8];

    tv[0]  = '{ADD, 5, 7, 0, 12, 0, 0, 0, 0};
    tv[1]  = '{SUB, 32'h1234, 32'h1234, 0, 0, 1, 0, 0, 0};
    tv[2]  = '{SLT, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0};
    tv[3]  = '{AND, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 0, 0, 0};
    tv[4]  = '{OR, 32'hF0F0, 32'h0F0F, 0, 32'hFFFF, 0, 0, 0, 0};
    tv[5]  = '{DIV, 32'hFFFFFFF9, 2, 1, 32'hFFFFFFFD, 0, 0,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[6]  = '{DIV, 10, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[7]  = '{ADD, 32'hFFFFFFFF, 1, 0, 0, 1, 0,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[8]  = '{4'b1111, 3, 4, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[9]  = '{DIV, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 0,
               0, 32'h80000000};
    tv[10] = '{DIV, 100, 7, 0, 14, 0, 0, 2, 14};
    tv[11] = '{SUB, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 2, 14};

    rst_n = 1'b0; start = 1'b0; alucontrol = '0; a = '0; b = '0;
    #1;
    chk("reset_result", result, 0);
    chk("reset_flags", {zero, busy, done, div_by_zero}, 0);
    chk("reset_hilo", {hi, lo}, 0);
    #12 rst_n = 1'b1;

    foreach (tv[i])
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].x, tv[i].y,
             tv[i].poke, tv[i].res, tv[i].z, tv[i].dbz, tv[i].eh,
             tv[i].el, (tv[i].op == DIV && tv[i].y != 0) ? W + 1 : 0);
    m_hi = 2; m_lo = 14;

    // Back-to-back: DIV 100/7, ADD 2+2 issued in the done cycle.
    @(negedge clk);
    start = 1'b1; alucontrol = DIV; a = 100; b = 7;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      @(posedge clk); #1; k++;
    end
    chk("b2b_div_lat", k, W + 1);
    chk("b2b_lo", lo, 14);
    chk("b2b_hi", hi, 2);
    start = 1'b1; alucontrol = ADD; a = 2; b = 2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_add_done", done, 1);
    chk("b2b_add_res", result, 4);
    chk("b2b_hilo_kept", {hi, lo}, {32'd2, 32'd14});

    // Reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; alucontrol = DIV; a = 100; b = 3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_result", result, 0);
    chk("rst_mid_flags", {zero, busy, done, div_by_zero}, 0);
    chk("rst_mid_hilo", {hi, lo}, 0);
    k = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) k++;
    end
    chk("rst_mid_no_done", k, 0);
    @(negedge clk) rst_n = 1'b1;
    m_hi = 0; m_lo = 0;
    run_op("rst_add", ADD, 1, 1, 0, 2, 0, 0, 0, 0, 0);

    // Random ops against the model.
    ops = '{ADD, SUB, SLT, AND, OR, DIV, DIV, 4'b0000};
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (i % 8 == 7) op = 4'($urandom);
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 20);
      if (op == DIV && $urandom_range(0, 7) == 0) y = 0;
      if ($urandom_range(0, 9) == 0) y = x;
      model(op, x, y, er, ez, ed, lat);
      run_op($sformatf("rnd%0d", i), op, x, y, 0, er, ez, ed,
             m_hi, m_lo, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request to execute an operation.
REQ-005 The block SHALL have port alucontrol, input, 4, operation code from the ALU decoder.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, operands.
REQ-007 The block SHALL have port result, output, WIDTH, registered operation result.
REQ-008 The block SHALL have port zero, output, 1, registered flag: result == 0.
REQ-009 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse marking valid result.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH each, division remainder and quotient registers.
REQ-012 The block SHALL have port div_by_zero, output, 1, registered error flag for DIV with b == 0.

Function
REQ-013 Opcodes SHALL be: 0010 ADD, 0110 SUB, 0111 SLT (signed), 0000 AND, 0001 OR, 1010 DIV (signed); any other code SHALL produce result 0, a done pulse, and no error.
REQ-014 The FSM SHALL have states IDLE, DIV, FIX; start is accepted only in IDLE; start in DIV or FIX SHALL be ignored.
REQ-015 a, b and alucontrol SHALL be captured on the accepting edge E0; later changes SHALL NOT affect the operation in flight.
REQ-016 Non-DIV ops SHALL update result and zero at E0, with done high for the following cycle only (latency 1); the FSM stays in IDLE.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow indication; SLT SHALL return 1 or 0, zero-extended.
REQ-018 DIV with b != 0 SHALL enter DIV at E0 and set busy; it SHALL perform one restoring shift-subtract iteration on operand magnitudes at each of edges E1..E_WIDTH, then enter FIX.
REQ-019 At E_WIDTH+1 (FIX), lo SHALL take the quotient truncated toward zero and hi the remainder carrying the sign of the dividend.
REQ-019a At that same edge, result SHALL equal lo, zero SHALL be updated, busy SHALL fall, done SHALL pulse, and the state SHALL return to IDLE.
REQ-020 Done-to-start: start asserted during the done cycle SHALL be accepted (back-to-back, no bubble).
REQ-021 DIV with b == 0 SHALL complete as a 1-cycle op: result 0, zero 1, div_by_zero 1, hi/lo unchanged.
REQ-022 div_by_zero SHALL be cleared by the next accepted operation that is not a divide-by-zero.
REQ-023 DIV of -2^(WIDTH-1) by -1 SHALL yield lo = 2^(WIDTH-1) (wrapped) and hi = 0 without error.
REQ-024 hi and lo SHALL change only on DIV completion; non-DIV ops SHALL leave them untouched.
REQ-025 done SHALL never be high for two consecutive cycles for one operation; busy and done SHALL never be high simultaneously.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE and result, zero, busy, done, hi, lo, div_by_zero to 0, regardless of clk.
REQ-027 Reset during DIV SHALL abort the division with no done pulse; the first rising edge with rst_n high SHALL accept start normally.

Verification
REQ-028 ADD: a=5, b=7, alucontrol=0010, start 1 cycle -> next cycle result=12, zero=0, done=1 for one cycle, busy=0.
REQ-029 SUB/SLT: a=b=0x1234 with 0110 -> result=0, zero=1; then a=0xFFFFFFFF, b=1 with 0111 -> result=1.
REQ-030 DIV: a=0xFFFFFFF9 (-7), b=2, start pulsed again mid-busy -> done exactly WIDTH+1 cycles after E0, lo=result=0xFFFFFFFD, hi=0xFFFFFFFF; the extra start is ignored.
REQ-031 Divide by zero: a=10, b=0 after the prior DIV -> done after 1 cycle, div_by_zero=1, result=0, hi/lo keep 0xFFFFFFFF/0xFFFFFFFD.
REQ-032 Reset mid-DIV: rst_n low 10 cycles into a=100, b=3 -> all outputs 0 at once, no done; after release, ADD 1+1 -> result=2.
REQ-033 Back-to-back: DIV 100/7 then start ADD 2+2 in the done cycle -> lo=14, hi=2, then result=4 one cycle later.
